// File: rtl/tictactoe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tictactoe_pkg
// Description : Shared encodings for the tic-tac-toe board, result codes and
//               the move arbiter state machine.
// Revision    : 1.0 - initial release
// ============================================================================
package tictactoe_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam int BOARD_CELLS = 9;

    localparam logic [1:0] OVER_NONE = 2'b00;
    localparam logic [1:0] OVER_X    = 2'b01;
    localparam logic [1:0] OVER_O    = 2'b10;
    localparam logic [1:0] OVER_DRAW = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_EVAL   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CHECK  = ST_CHECK,
        EVAL   = ST_EVAL,
        SETTLE = ST_SETTLE,
        OVER   = ST_OVER
    } arb_state_t;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : move_arbiter_if
// Description : Requester handshakes, board read/write port and game status
//               bundled for the move arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_arbiter_if;

    logic       req_h;
    logic [3:0] addr_h;
    logic       req_c;
    logic [3:0] addr_c;
    logic       done_h;
    logic       done_c;
    logic       ok;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] waddr;
    logic [1:0] wd;
    logic       wen;
    logic [1:0] win;
    logic [1:0] turn;
    logic [1:0] over;
    logic       timeout;

    modport slave (
        input  req_h, addr_h, req_c, addr_c, rd_data, win,
        output done_h, done_c, ok, rd_addr, waddr, wd, wen, turn, over, timeout
    );

    modport master (
        output req_h, addr_h, req_c, addr_c, rd_data, win,
        input  done_h, done_c, ok, rd_addr, waddr, wd, wen, turn, over, timeout
    );

endinterface
`default_nettype wire

// File: rtl/move_arbiter_move_timer.sv
`default_nettype none
// ============================================================================
// Module      : move_timer
// Description : Idle-turn counter; o_expire pulses on the TIMEOUT_CYCLES-th
//               consecutive cycle that i_run is held high.
// Revision    : 1.0 - initial release
// ============================================================================
module move_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    output logic      o_expire
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    assign o_expire = i_run && (r_count == c_LAST);

    // Dropping i_run (state change) or expiring (turn flip) restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !i_run || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/move_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : move_arbiter
// Description : Turn controller and board write-port arbiter for tic-tac-toe.
//               Optional forfeit timer enabled by defining MOVE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module move_arbiter
    import tictactoe_pkg::*;
#(
    parameter logic [1:0]  FIRST_PLAYER   = 2'b01,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    move_arbiter_if.slave   bus
);

    localparam logic [3:0] c_MAX_MOVES = 4'(BOARD_CELLS);
    localparam logic [3:0] c_MAX_ADDR  = 4'(BOARD_CELLS - 1);

    if ((FIRST_PLAYER != CELL_X) && (FIRST_PLAYER != CELL_O)) begin : g_bad_first
        $error("FIRST_PLAYER must be 2'b01 or 2'b10");
    end

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t r_state;
    logic [1:0] r_turn;
    logic [3:0] r_addr;
    logic [3:0] r_rd_addr;
    logic [3:0] r_moves;
    logic [1:0] r_over;

    logic       w_req_on;
    logic [3:0] w_addr_on;
    logic       w_eval;
    logic       w_legal;
    logic       w_timeout;

    // Only the on-turn requester is visible; the other stays pending untouched.
    assign w_req_on  = (r_turn == CELL_X) ? bus.req_h  : bus.req_c;
    assign w_addr_on = (r_turn == CELL_X) ? bus.addr_h : bus.addr_c;
    assign w_eval    = (r_state == EVAL);
    assign w_legal   = (r_addr <= c_MAX_ADDR) && (bus.rd_data == CELL_EMPTY);

`ifdef MOVE_TIMEOUT_EN
    logic w_timer_run;

    assign w_timer_run = (r_state == IDLE) && !w_req_on;

    move_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_move_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_timer_run),
        .o_expire (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_turn    <= FIRST_PLAYER;
            r_addr    <= 4'd0;
            r_rd_addr <= 4'd0;
            r_moves   <= 4'd0;
            r_over    <= OVER_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_on) begin
                        r_addr    <= w_addr_on;
                        r_rd_addr <= w_addr_on;
                        r_state   <= CHECK;
                    end else if (w_timeout) begin
                        r_turn <= other_player(r_turn);
                    end
                end
                CHECK: begin
                    r_state <= EVAL;
                end
                EVAL: begin
                    if (w_legal) begin
                        if (r_moves != c_MAX_MOVES) begin
                            r_moves <= r_moves + 4'd1;
                        end
                        r_state <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETTLE: begin
                    if (bus.win != OVER_NONE) begin
                        r_over  <= bus.win;
                        r_turn  <= CELL_EMPTY;
                        r_state <= OVER;
                    end else if (r_moves == c_MAX_MOVES) begin
                        r_over  <= OVER_DRAW;
                        r_turn  <= CELL_EMPTY;
                        r_state <= OVER;
                    end else begin
                        r_turn  <= other_player(r_turn);
                        r_state <= IDLE;
                    end
                end
                OVER: begin
                    r_state <= OVER;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Completion and write strobes are decided in EVAL, when rd_data is valid.
    assign bus.done_h  = w_eval && (r_turn == CELL_X);
    assign bus.done_c  = w_eval && (r_turn == CELL_O);
    assign bus.ok      = w_eval && w_legal;
    assign bus.wen     = w_eval && w_legal;
    assign bus.waddr   = r_addr;
    assign bus.wd      = (w_eval && w_legal) ? r_turn : CELL_EMPTY;
    assign bus.rd_addr = r_rd_addr;
    assign bus.turn    = r_turn;
    assign bus.over    = r_over;
    assign bus.timeout = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_arbiter
// Description : Self-checking bench for move_arbiter with a behavioural board.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_arbiter;

    typedef struct {
        bit         rst_before;
        bit         cpu;
        logic [3:0] addr;
        logic [1:0] win;
        bit         exp_ok;
        logic [1:0] exp_turn;
        logic [1:0] exp_over;
    } vec_t;

    typedef struct {
        bit         cpu;
        bit         ok;
        logic [3:0] addr;
        logic [1:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wen_cnt = 0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    exp_t sb[$];
    vec_t vecs[17];
    logic [1:0] board [0:8];

    always #5 clk = ~clk;

    move_arbiter_if bus ();

    move_arbiter #(
        .FIRST_PLAYER   (2'b01),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Board register array: registered read, out-of-range reads return empty.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) board[i] <= 2'b00;
        end else if (bus.wen && bus.waddr < 4'd9) begin
            board[bus.waddr] <= bus.wd;
        end
        bus.rd_data <= (bus.rd_addr < 4'd9) ? board[bus.rd_addr] : 2'b00;
    end

    always @(posedge clk) begin
        if (bus.wen) wen_cnt <= wen_cnt + 1;
        if (bus.done_h || bus.done_c) done_cnt <= done_cnt + 1;
        if (bus.timeout) to_cnt <= to_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_h = 1'b0; bus.req_c = 1'b0; bus.win = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic take_done();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected done: done_h %0b done_c %0b with empty scoreboard", bus.done_h, bus.done_c);
            return;
        end
        e = sb.pop_front();
        chk("done_c", bus.done_c, e.cpu);
        chk("done_h", bus.done_h, !e.cpu);
        chk("ok", bus.ok, e.ok);
        chk("wen", bus.wen, e.ok);
        if (e.ok) begin
            chk("waddr", bus.waddr, e.addr);
            chk("wd", bus.wd, e.wd);
        end
        if (e.cpu) bus.req_c = 1'b0;
        else       bus.req_h = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (bus.done_h || bus.done_c) begin
                take_done();
                got++;
            end
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL done wait: got %0d dones expected %0d", got, n);
        end
    endtask

    task automatic push_req(input bit cpu, input logic [3:0] addr, input bit ok);
        exp_t e;
        e.cpu = cpu; e.ok = ok; e.addr = addr;
        e.wd  = cpu ? 2'b10 : 2'b01;
        sb.push_back(e);
        if (cpu) begin bus.req_c = 1'b1; bus.addr_c = addr; end
        else     begin bus.req_h = 1'b1; bus.addr_h = addr; end
    endtask

    task automatic run_vec(input vec_t v);
        if (v.rst_before) do_reset();
        push_req(v.cpu, v.addr, v.exp_ok);
        wait_dones(1, 12);
        bus.win = v.win;
        repeat (2) @(negedge clk);
        bus.win = 2'b00;
        chk("turn after move", bus.turn, v.exp_turn);
        chk("over after move", bus.over, v.exp_over);
    endtask

    task automatic no_done_after_over();
        int d0 = done_cnt;
        int w0 = wen_cnt;
        bus.req_h = 1'b1; bus.addr_h = 4'd5;
        bus.req_c = 1'b1; bus.addr_c = 4'd6;
        repeat (8) @(negedge clk);
        chk("over ignores done", done_cnt, d0);
        chk("over ignores wen", wen_cnt, w0);
        chk("over turn", bus.turn, 2'b00);
        bus.req_h = 1'b0; bus.req_c = 1'b0;
    endtask

    function automatic vec_t mkv(bit r, bit c, logic [3:0] a, logic [1:0] w,
                                 bit ok, logic [1:0] t, logic [1:0] o);
        vec_t v;
        v.rst_before = r; v.cpu = c; v.addr = a; v.win = w;
        v.exp_ok = ok; v.exp_turn = t; v.exp_over = o;
        return v;
    endfunction

    initial begin
        int d0;
        int w0;
        bit seen;
        bus.req_h = 1'b0; bus.addr_h = 4'd0;
        bus.req_c = 1'b0; bus.addr_c = 4'd0;
        bus.win   = 2'b00;

        // Draw game with a rejected occupied cell and an out-of-range address.
        vecs[0]  = mkv(1, 0, 4'd4,  2'b00, 1, 2'b10, 2'b00);
        vecs[1]  = mkv(0, 1, 4'd4,  2'b00, 0, 2'b10, 2'b00);
        vecs[2]  = mkv(0, 1, 4'd0,  2'b00, 1, 2'b01, 2'b00);
        vecs[3]  = mkv(0, 0, 4'd12, 2'b00, 0, 2'b01, 2'b00);
        vecs[4]  = mkv(0, 0, 4'd1,  2'b00, 1, 2'b10, 2'b00);
        vecs[5]  = mkv(0, 1, 4'd2,  2'b00, 1, 2'b01, 2'b00);
        vecs[6]  = mkv(0, 0, 4'd3,  2'b00, 1, 2'b10, 2'b00);
        vecs[7]  = mkv(0, 1, 4'd5,  2'b00, 1, 2'b01, 2'b00);
        vecs[8]  = mkv(0, 0, 4'd6,  2'b00, 1, 2'b10, 2'b00);
        vecs[9]  = mkv(0, 1, 4'd7,  2'b00, 1, 2'b01, 2'b00);
        vecs[10] = mkv(0, 0, 4'd8,  2'b00, 1, 2'b00, 2'b11);
        // X takes the top row; the board reports the win after the third write.
        vecs[11] = mkv(1, 0, 4'd0,  2'b00, 1, 2'b10, 2'b00);
        vecs[12] = mkv(0, 1, 4'd3,  2'b00, 1, 2'b01, 2'b00);
        vecs[13] = mkv(0, 0, 4'd1,  2'b00, 1, 2'b10, 2'b00);
        vecs[14] = mkv(0, 1, 4'd4,  2'b00, 1, 2'b01, 2'b00);
        vecs[15] = mkv(0, 0, 4'd2,  2'b01, 1, 2'b00, 2'b01);
        // Prefix for the both-requesters sequence.
        vecs[16] = mkv(1, 0, 4'd0,  2'b00, 1, 2'b10, 2'b00);

        do_reset();
        chk("reset done_h", bus.done_h, 1'b0);
        chk("reset done_c", bus.done_c, 1'b0);
        chk("reset ok", bus.ok, 1'b0);
        chk("reset wen", bus.wen, 1'b0);
        chk("reset timeout", bus.timeout, 1'b0);
        chk("reset rd_addr", bus.rd_addr, 4'd0);
        chk("reset waddr", bus.waddr, 4'd0);
        chk("reset wd", bus.wd, 2'b00);
        chk("reset over", bus.over, 2'b00);
        chk("reset turn", bus.turn, 2'b01);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].exp_over != 2'b00) no_done_after_over();
        end

        // Both requesters held while CPU is on turn: CPU first, then X.
        push_req(1'b1, 4'd2, 1'b1);
        push_req(1'b0, 4'd1, 1'b1);
        wait_dones(2, 30);
        repeat (2) @(negedge clk);
        chk("both held final turn", bus.turn, 2'b10);
        chk("both held over", bus.over, 2'b00);

        // Reset asserted while the move sits in CHECK aborts it.
        do_reset();
        d0 = done_cnt;
        w0 = wen_cnt;
        bus.req_h = 1'b1; bus.addr_h = 4'd5;
        @(negedge clk);
        rst = 1'b1;
        bus.req_h = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort no done", done_cnt, d0);
        chk("abort no wen", wen_cnt, w0);
        chk("abort turn", bus.turn, 2'b01);

`ifdef MOVE_TIMEOUT_EN
        do_reset();
        w0 = wen_cnt;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.timeout) seen = 1'b1;
        end
        chk("timeout pulse", seen, 1'b1);
        chk("timeout turn before flip", bus.turn, 2'b01);
        @(negedge clk);
        chk("timeout one cycle", bus.timeout, 1'b0);
        chk("timeout turn flip", bus.turn, 2'b10);
        chk("timeout no write", wen_cnt, w0);
`else
        seen = 1'b0;
        chk("timeout never pulses", to_cnt, 0);
`endif

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
